// File: rtl/cms_and_pipe.sv
// Masked AND gadget (CMS-style, ring refresh) for NSHARES shares of W-bit lanes.
// Refreshed cross products are registered before compression; optional output register.
module cms_and_pipe #(
  parameter int NSHARES = 4,
  parameter int W       = 1,
  parameter int OUT_REG = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NSHARES*W-1:0]           a,
  input  logic [NSHARES*W-1:0]           b,
  input  logic [NSHARES*NSHARES*W-1:0]   rnd,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NSHARES*W-1:0]           c
);

  localparam int T = NSHARES * NSHARES;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready never looks at in_valid; a held output stays bit-exact until out_ready.

  logic [T*W-1:0]         t_d;
  logic [T*W-1:0]         s1_t;
  logic                   s1_valid;
  logic                   s1_load;
  logic [NSHARES*W-1:0]   comp;

  // Each cross product is masked by its own rnd value and its ring neighbour's.
  always_comb begin
    t_d = '0;
    for (int i = 0; i < NSHARES; i++) begin
      for (int j = 0; j < NSHARES; j++) begin
        t_d[(i*NSHARES+j)*W +: W] = (a[i*W +: W] & b[j*W +: W])
                                    ^ rnd[(i*NSHARES+j)*W +: W]
                                    ^ rnd[(((i*NSHARES+j)+1) % T)*W +: W];
      end
    end
  end

  // Glitch barrier: only individually refreshed terms are stored here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_t     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) s1_t <= t_d;
    end
  end

  always_comb begin
    comp = '0;
    for (int i = 0; i < NSHARES; i++) begin
      for (int j = 0; j < NSHARES; j++) begin
        comp[i*W +: W] = comp[i*W +: W] ^ s1_t[(i*NSHARES+j)*W +: W];
      end
    end
  end

  assign in_ready = s1_load;

  if (OUT_REG != 0) begin : g_out_reg
    logic                 s2_valid;
    logic                 s2_load;
    logic [NSHARES*W-1:0] c_q;

    assign s2_load = !s2_valid || out_ready;
    assign s1_load = !s1_valid || s2_load;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        c_q      <= '0;
      end else if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) c_q <= comp;
      end
    end

    assign c         = c_q;
    assign out_valid = s2_valid;
  end else begin : g_out_comb
    assign s1_load   = !s1_valid || out_ready;
    assign c         = comp;
    assign out_valid = s1_valid;
  end

endmodule

// File: tb/tb_cms_and_pipe.sv
// Bench for cms_and_pipe: a 4-share/1-bit registered-output instance and a
// 3-share/8-bit combinational-output instance, checked against a share-level model.
module tb_cms_and_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  a, b, c;
  logic [15:0] rnd;

  logic        in_valid0, in_ready0, out_valid0, out_ready0;
  logic [23:0] a0, b0, c0;
  logic [71:0] rnd0;

  int n_pass = 0;
  int n_chk  = 0;
  int n_acc  = 0;
  int n_acc0 = 0;

  logic [3:0]  exp_q[$];
  logic [7:0]  par_q[$];
  logic [23:0] exp0_q[$];

  cms_and_pipe #(.NSHARES(4), .W(1), .OUT_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready), .c(c)
  );

  cms_and_pipe #(.NSHARES(3), .W(8), .OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .rnd(rnd0), .out_valid(out_valid0), .out_ready(out_ready0), .c(c0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, expv);
  endtask

  // c_i = XOR over j of (a_i & b_j ^ r_k ^ r_(k+1 mod n*n)), k = i*n+j, lane by lane.
  function automatic logic [31:0] model(input int n, input int w, input logic [31:0] av,
                                        input logic [31:0] bv, input logic [127:0] rv);
    logic [31:0] cv;
    int k;
    cv = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        for (int l = 0; l < w; l++) begin
          k = i*n + j;
          cv[i*w+l] = cv[i*w+l] ^ (av[i*w+l] & bv[j*w+l]) ^ rv[k*w+l] ^ rv[((k+1) % (n*n))*w+l];
        end
    return cv;
  endfunction

  // Unmasked value: XOR of all shares, lane by lane.
  function automatic logic [7:0] fold(input int n, input int w, input logic [31:0] v);
    logic [7:0] f;
    f = '0;
    for (int i = 0; i < n; i++)
      for (int l = 0; l < w; l++) f[l] = f[l] ^ v[i*w+l];
    return f;
  endfunction

  // Called just after a falling edge with inputs driven; scores this cycle's transfers.
  task automatic cycle();
    logic acc, del, acc0, del0;
    #1;
    acc  = in_valid && in_ready;
    del  = out_valid && out_ready;
    acc0 = in_valid0 && in_ready0;
    del0 = out_valid0 && out_ready0;
    if (del) begin
      if (exp_q.size() == 0) check("spurious_out", 32'(exp_q.size()), 32'd1);
      else begin
        check("c4", 32'(c), 32'(exp_q.pop_front()));
        check("parity4", 32'(fold(4, 1, 32'(c))), 32'(par_q.pop_front()));
      end
    end
    if (del0) begin
      if (exp0_q.size() == 0) check("spurious_out0", 32'(exp0_q.size()), 32'd1);
      else check("c3x8", 32'(c0), 32'(exp0_q.pop_front()));
    end
    if (acc) begin
      n_acc++;
      exp_q.push_back(4'(model(4, 1, 32'(a), 32'(b), 128'(rnd))));
      par_q.push_back(fold(4, 1, 32'(a)) & fold(4, 1, 32'(b)));
    end
    if (acc0) begin
      n_acc0++;
      exp0_q.push_back(24'(model(3, 8, 32'(a0), 32'(b0), 128'(rnd0))));
    end
    @(negedge clk);
  endtask

  task automatic rand_op();
    a   = 4'($urandom);
    b   = 4'($urandom);
    rnd = 16'($urandom);
  endtask

  task automatic rand_op0();
    a0   = 24'($urandom);
    b0   = 24'($urandom);
    rnd0 = {8'($urandom), $urandom, $urandom};
  endtask

  task automatic drain();
    in_valid   = 1'b0;
    in_valid0  = 1'b0;
    out_ready  = 1'b1;
    out_ready0 = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() + exp0_q.size()) != 0; i++) cycle();
    #1;
    check("drain_empty", 32'(exp_q.size() + exp0_q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_out_valid0", 32'(out_valid0), 32'd0);
  endtask

  logic [3:0] held;

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; rnd = '0;
    in_valid0 = 1'b0; out_ready0 = 1'b1; a0 = '0; b0 = '0; rnd0 = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid0", 32'(out_valid0), 32'd0);
    check("rst_c0", 32'(c0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: rnd=0, a=0001, b=0111 -> c=0001 two cycles later.
    a = 4'b0001; b = 4'b0111; rnd = 16'h0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    #1 check("lat_not_yet", 32'(out_valid), 32'd0);
    cycle();
    #1 check("lat2_valid", 32'(out_valid), 32'd1);
    check("lat2_c", 32'(c), 32'h1);
    drain();

    // Fixed rnd, then an operand whose unmasked value is 0, then exhaustive shares.
    a = 4'b0001; b = 4'b0111; rnd = 16'hA5C3; in_valid = 1'b1;
    cycle();
    a = 4'b0011;
    cycle();
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++) begin
        a = 4'(av); b = 4'(bv); rnd = 16'($urandom); in_valid = 1'b1;
        cycle();
      end
    drain();

    // Stall: out_ready low, only two ops fit, output held, then all eight in order.
    n_acc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; rand_op();
      cycle();
    end
    #1;
    check("stall_accepted", 32'(n_acc), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    held = c;
    for (int i = 0; i < 3; i++) begin
      rand_op();
      cycle();
    end
    #1 check("stall_c_held", 32'(c), 32'(held));
    out_ready = 1'b1;
    for (int i = 0; i < 20 && n_acc < 8; i++) begin
      rand_op();
      cycle();
    end
    check("stall_total", 32'(n_acc), 32'd8);
    drain();

    // Reset with both stages full discards everything at once.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_op();
      cycle();
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_c", 32'(c), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete(); par_q.delete(); exp0_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; rand_op();
    cycle();
    in_valid = 1'b0;
    #1 check("postrst_lat1", 32'(out_valid), 32'd0);
    cycle();
    #1 check("postrst_lat2", 32'(out_valid), 32'd1);
    drain();

    // 3-share 8-bit combinational-output instance.
    a0 = {8'h00, 8'h0F, 8'hFF}; b0 = {8'h00, 8'h00, 8'h3C}; rnd0 = '0; in_valid0 = 1'b1;
    cycle();
    in_valid0 = 1'b0;
    #1;
    check("n3_valid", 32'(out_valid0), 32'd1);
    check("n3_c", 32'(c0), 32'h000C3C);
    cycle();
    n_acc0 = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid0 = 1'b1; rand_op0();
      cycle();
    end
    check("n3_throughput", 32'(n_acc0), 32'd20);
    drain();

    // Random valid/ready traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_valid0  = ($urandom_range(0, 2) != 0);
      out_ready0 = ($urandom_range(0, 3) != 0);
      rand_op();
      rand_op0();
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
